// File: rtl/mem_arbiter.sv
// Memory port arbiter: shares one memory port between I-side line fills and
// D-side line fills / single-word writes, one transaction at a time.
module mem_arbiter #(
  parameter int MEM_LATENCY = 4,
  parameter bit D_PRIORITY  = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_ack,
  output logic [63:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [63:0] d_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          own_d;     // 1: D-side owns the current transaction
  logic          last_d;    // 1: most recent grant went to D-side
  logic          we_q;
  logic [15:0]   addr_q;
  logic [15:0]   wdata_q;
  logic          grant_d;
  logic          last_cycle;
  logic          busy;

  assign last_cycle = (cnt == CW'(MEM_LATENCY - 1));
  assign busy       = (state == BUSY);

  // Tie resolution: fixed D priority, or round-robin against the last winner.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    grant_d = d_req;
    if (i_req && d_req) begin
      grant_d = D_PRIORITY ? 1'b1 : !last_d;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_req || d_req) state_nxt = BUSY;
      BUSY:    if (last_cycle)     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      own_d   <= 1'b0;
      last_d  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (i_req || d_req) begin
            own_d   <= grant_d;
            last_d  <= grant_d;
            we_q    <= grant_d & d_we;
            addr_q  <= grant_d ? d_addr : i_addr;
            wdata_q <= (grant_d && d_we) ? d_wdata : 16'h0000;
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (last_cycle && !we_q) begin
            if (own_d) d_rdata <= mem_rdata;
            else       i_rdata <= mem_rdata;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  // Command and ack outputs are decoded from state, so an asynchronous reset
  // drops them in the same cycle it is asserted.
  always_comb begin
    mem_read  = busy && !we_q;
    mem_write = busy && we_q;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    if (busy) begin
      mem_addr  = we_q ? addr_q : {addr_q[15:2], 2'b00};
      mem_wdata = we_q ? wdata_q : 16'h0000;
    end
    i_ack = (state == DONE) && !own_d;
    d_ack = (state == DONE) && own_d;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances cover fixed D priority,
// round-robin ties, and single-cycle memory latency.
module tb_mem_arbiter;

  logic clk;
  logic reset_n;

  int n_checks;
  int n_fail;

  // Instance a: D_PRIORITY=1, MEM_LATENCY=4
  logic        a_i_req, a_i_ack, a_d_req, a_d_we, a_d_ack, a_mem_read, a_mem_write;
  logic [15:0] a_i_addr, a_d_addr, a_d_wdata, a_mem_addr, a_mem_wdata;
  logic [63:0] a_i_rdata, a_d_rdata, a_mem_rdata;
  // Instance b: D_PRIORITY=0, MEM_LATENCY=4
  logic        b_i_req, b_i_ack, b_d_req, b_d_we, b_d_ack, b_mem_read, b_mem_write;
  logic [15:0] b_i_addr, b_d_addr, b_d_wdata, b_mem_addr, b_mem_wdata;
  logic [63:0] b_i_rdata, b_d_rdata, b_mem_rdata;
  // Instance c: D_PRIORITY=1, MEM_LATENCY=1
  logic        c_i_req, c_i_ack, c_d_req, c_d_we, c_d_ack, c_mem_read, c_mem_write;
  logic [15:0] c_i_addr, c_d_addr, c_d_wdata, c_mem_addr, c_mem_wdata;
  logic [63:0] c_i_rdata, c_d_rdata, c_mem_rdata;

  mem_arbiter #(.MEM_LATENCY(4), .D_PRIORITY(1'b1)) u_a (
    .clk(clk), .reset_n(reset_n),
    .i_req(a_i_req), .i_addr(a_i_addr), .i_ack(a_i_ack), .i_rdata(a_i_rdata),
    .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_ack(a_d_ack), .d_rdata(a_d_rdata),
    .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  mem_arbiter #(.MEM_LATENCY(4), .D_PRIORITY(1'b0)) u_b (
    .clk(clk), .reset_n(reset_n),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_ack(b_i_ack), .i_rdata(b_i_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_ack(b_d_ack), .d_rdata(b_d_rdata),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  mem_arbiter #(.MEM_LATENCY(1), .D_PRIORITY(1'b1)) u_c (
    .clk(clk), .reset_n(reset_n),
    .i_req(c_i_req), .i_addr(c_i_addr), .i_ack(c_i_ack), .i_rdata(c_i_rdata),
    .d_req(c_d_req), .d_we(c_d_we), .d_addr(c_d_addr), .d_wdata(c_d_wdata),
    .d_ack(c_d_ack), .d_rdata(c_d_rdata),
    .mem_read(c_mem_read), .mem_write(c_mem_write), .mem_addr(c_mem_addr),
    .mem_wdata(c_mem_wdata), .mem_rdata(c_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge: inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    {a_i_req, a_d_req, a_d_we} = '0; a_i_addr = '0; a_d_addr = '0; a_d_wdata = '0; a_mem_rdata = '0;
    {b_i_req, b_d_req, b_d_we} = '0; b_i_addr = '0; b_d_addr = '0; b_d_wdata = '0; b_mem_rdata = '0;
    {c_i_req, c_d_req, c_d_we} = '0; c_i_addr = '0; c_d_addr = '0; c_d_wdata = '0; c_mem_rdata = '0;

    // Reset state
    tick(); tick();
    check("rst_mem_read",  a_mem_read,  1'b0);
    check("rst_mem_write", a_mem_write, 1'b0);
    check("rst_mem_addr",  a_mem_addr,  16'h0000);
    check("rst_mem_wdata", a_mem_wdata, 16'h0000);
    check("rst_i_ack",     a_i_ack,     1'b0);
    check("rst_d_ack",     a_d_ack,     1'b0);
    check("rst_i_rdata",   a_i_rdata,   64'h0);
    check("rst_d_rdata",   a_d_rdata,   64'h0);
    reset_n = 1'b1;
    tick();

    // I-side line read: mem_read cycles 1-4, ack in cycle 5
    a_i_req = 1'b1; a_i_addr = 16'h0013; a_mem_rdata = 64'h4444_3333_2222_1111;
    tick();
    check("t2_mem_addr", a_mem_addr, 16'h0010);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("t2_mem_read_c%0d", k), a_mem_read, 1'b1);
      check($sformatf("t2_i_ack_low_c%0d", k), a_i_ack, 1'b0);
      tick();
    end
    check("t2_mem_read_c5", a_mem_read, 1'b0);
    check("t2_mem_addr_c5", a_mem_addr, 16'h0000);
    check("t2_i_ack_c5",    a_i_ack,    1'b1);
    check("t2_d_ack_c5",    a_d_ack,    1'b0);
    check("t2_i_rdata",     a_i_rdata,  64'h4444_3333_2222_1111);
    tick();
    check("t2_i_ack_c6", a_i_ack, 1'b0);
    a_i_req = 1'b0;
    tick();

    // Simultaneous requests with D priority: D first, I after one IDLE cycle
    a_i_req = 1'b1; a_i_addr = 16'h0044;
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 16'h0020;
    a_mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    tick();
    check("t3_d_mem_addr", a_mem_addr, 16'h0020);
    check("t3_d_mem_read", a_mem_read, 1'b1);
    tick(); tick(); tick(); tick();
    check("t3_d_ack",   a_d_ack,   1'b1);
    check("t3_i_noack", a_i_ack,   1'b0);
    check("t3_d_rdata", a_d_rdata, 64'hAAAA_BBBB_CCCC_DDDD);
    check("t3_i_rdata_held", a_i_rdata, 64'h4444_3333_2222_1111);
    a_mem_rdata = 64'h5555_6666_7777_8888;
    tick();
    check("t3_idle_mem_read", a_mem_read, 1'b0);
    check("t3_idle_d_ack",    a_d_ack,    1'b0);
    a_d_req = 1'b0;
    tick();
    check("t3_i_mem_addr", a_mem_addr, 16'h0044);
    check("t3_i_mem_read", a_mem_read, 1'b1);
    tick(); tick(); tick(); tick();
    check("t3_i_ack",   a_i_ack,   1'b1);
    check("t3_i_rdata", a_i_rdata, 64'h5555_6666_7777_8888);
    check("t3_d_rdata_held", a_d_rdata, 64'hAAAA_BBBB_CCCC_DDDD);
    tick();
    a_i_req = 1'b0;
    tick();

    // D-side single-word write
    a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = 16'h0025; a_d_wdata = 16'hBEEF;
    a_mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
    tick();
    check("t5_mem_addr",  a_mem_addr,  16'h0025);
    check("t5_mem_wdata", a_mem_wdata, 16'hBEEF);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("t5_mem_write_c%0d", k), a_mem_write, 1'b1);
      check($sformatf("t5_mem_read_c%0d", k),  a_mem_read,  1'b0);
      tick();
    end
    check("t5_mem_write_c5", a_mem_write, 1'b0);
    check("t5_mem_wdata_c5", a_mem_wdata, 16'h0000);
    check("t5_d_ack",        a_d_ack,     1'b1);
    check("t5_d_rdata_held", a_d_rdata,   64'hAAAA_BBBB_CCCC_DDDD);
    tick();
    a_d_req = 1'b0; a_d_we = 1'b0;
    tick();

    // Reset asserted mid-BUSY: outputs drop immediately, no ack afterwards
    a_i_req = 1'b1; a_i_addr = 16'h0013;
    tick();
    tick();
    check("t1_pre_mem_read", a_mem_read, 1'b1);
    reset_n = 1'b0;
    #1;
    check("t1_mem_read",  a_mem_read, 1'b0);
    check("t1_mem_addr",  a_mem_addr, 16'h0000);
    check("t1_i_ack",     a_i_ack,    1'b0);
    check("t1_i_rdata",   a_i_rdata,  64'h0);
    check("t1_d_rdata",   a_d_rdata,  64'h0);
    a_i_req = 1'b0;
    #1;
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("t1_no_i_ack_%0d", k), a_i_ack, 1'b0);
      check($sformatf("t1_no_read_%0d", k),  a_mem_read, 1'b0);
    end

    // Round-robin ties: I,D,I,D starting with I after reset
    b_i_addr = 16'h0100; b_d_addr = 16'h0200; b_d_we = 1'b0;
    b_mem_rdata = 64'h0101_0202_0303_0404;
    b_i_req = 1'b1; b_d_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("t4_grant%0d_addr", k), b_mem_addr, (k % 2 == 0) ? 16'h0100 : 16'h0200);
      check($sformatf("t4_grant%0d_read", k), b_mem_read, 1'b1);
      if (k > 0) begin
        if (k % 2 == 0) b_d_req = 1'b1;
        else            b_i_req = 1'b1;
      end
      tick(); tick(); tick(); tick();
      check($sformatf("t4_grant%0d_i_ack", k), b_i_ack, (k % 2 == 0) ? 1'b1 : 1'b0);
      check($sformatf("t4_grant%0d_d_ack", k), b_d_ack, (k % 2 == 0) ? 1'b0 : 1'b1);
      tick();
      if (k % 2 == 0) b_i_req = 1'b0;
      else            b_d_req = 1'b0;
    end
    b_i_req = 1'b0; b_d_req = 1'b0;
    tick();

    // MEM_LATENCY=1: one read cycle, ack in cycle 2
    c_i_req = 1'b1; c_i_addr = 16'h0031; c_mem_rdata = 64'h0123_4567_89AB_CDEF;
    tick();
    check("t6_mem_read_c1", c_mem_read, 1'b1);
    check("t6_mem_addr_c1", c_mem_addr, 16'h0030);
    check("t6_i_ack_c1",    c_i_ack,    1'b0);
    tick();
    check("t6_mem_read_c2", c_mem_read, 1'b0);
    check("t6_i_ack_c2",    c_i_ack,    1'b1);
    check("t6_i_rdata",     c_i_rdata,  64'h0123_4567_89AB_CDEF);
    tick();
    check("t6_i_ack_c3", c_i_ack, 1'b0);
    c_i_req = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
